// File: rtl/booth_mul_pkg.sv
// Shared types and sizing helpers for the sequential radix-4 Booth multiplier.
package booth_mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // One recoded Booth digit: magnitude one or two, optionally negated.
  typedef struct packed {
    logic neg;
    logic one;
    logic two;
  } booth_digit_t;

  // Operand width after extension, rounded up to an even count with headroom for the sign.
  function automatic int ext_width(input int width);
    return 2 * ((width + 2) / 2);
  endfunction

  function automatic int iter_cnt(input int width);
    return ext_width(width) / 2;
  endfunction

endpackage

// File: rtl/booth_r4_digit_enc.sv
// Radix-4 Booth recoder: 3-bit multiplier window -> digit in {-2..+2}.
module booth_r4_digit_enc
  import booth_mul_pkg::*;
(
  input  logic [2:0]   window,
  output booth_digit_t digit
);

  // Recode the window; 000 and 111 both mean zero and never set neg.
  always_comb begin
    digit = '0;
    case (window)
      3'b001, 3'b010: digit.one = 1'b1;
      3'b011: digit.two = 1'b1;
      3'b100: begin
        digit.neg = 1'b1;
        digit.two = 1'b1;
      end
      3'b101, 3'b110: begin
        digit.neg = 1'b1;
        digit.one = 1'b1;
      end
      default: digit = '0;
    endcase
  end

endmodule

// File: rtl/booth_multiplier_r4_seq.sv
// Sequential radix-4 Booth multiplier, one digit per cycle, valid/ready on both sides.
// Optional BOOTH_MUL_ZERO_SKIP_EN: zero operands bypass the digit iterations.
module booth_multiplier_r4_seq
  import booth_mul_pkg::*;
#(
  parameter int WIDTH = 9,
  parameter int TAG_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic                 in_signed,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_product,
  output logic [TAG_W-1:0]     out_tag,
  output logic                 busy
);

  localparam int EW    = ext_width(WIDTH);
  localparam int ITER  = iter_cnt(WIDTH);
  localparam int ACC_W = 2 * EW + 1;
  localparam int CNT_W = $clog2(ITER + 1);
  localparam logic [CNT_W-1:0] ITER_C = CNT_W'(ITER);

  state_t                    state_r;
  state_t                    state_nxt_s;
  logic [EW-1:0]             a_r;
  logic [EW-1:0]             b_r;
  logic                      prev_r;
  logic [CNT_W-1:0]          cnt_r;
  logic signed [ACC_W-1:0]   acc_r;
  logic [2*WIDTH-1:0]        product_r;
  logic [TAG_W-1:0]          tag_r;

  logic [EW-1:0]             a_ext_s;
  logic [EW-1:0]             b_ext_s;
  logic                      zero_skip_s;
  booth_digit_t              digit_s;
  logic signed [ACC_W-1:0]   a_wide_s;
  logic signed [ACC_W-1:0]   mag_s;
  logic signed [ACC_W-1:0]   term_s;
  logic signed [ACC_W-1:0]   acc_sum_s;
  logic signed [ACC_W-1:0]   acc_shift_s;

  assign in_ready    = (state_r == IDLE) && rst_n;
  assign out_valid   = (state_r == DONE);
  assign busy        = (state_r != IDLE);
  assign out_product = product_r;
  assign out_tag     = tag_r;

  booth_r4_digit_enc u_enc (
    .window ({b_r[1:0], prev_r}),
    .digit  (digit_s)
  );

  // Operand extension and zero detection at the accepting edge.
  always_comb begin
    a_ext_s = {{(EW-WIDTH){in_signed & in_a[WIDTH-1]}}, in_a};
    b_ext_s = {{(EW-WIDTH){in_signed & in_b[WIDTH-1]}}, in_b};
`ifdef BOOTH_MUL_ZERO_SKIP_EN
    zero_skip_s = (in_a == '0) || (in_b == '0);
`else
    zero_skip_s = 1'b0;
`endif
  end

  // Add digit*a at bit EW, then shift right by 2; after ITER steps acc holds the exact product.
  always_comb begin
    a_wide_s = {{(ACC_W-EW){a_r[EW-1]}}, a_r};
    mag_s    = '0;
    if (digit_s.two) begin
      mag_s = a_wide_s <<< 1;
    end else if (digit_s.one) begin
      mag_s = a_wide_s;
    end else begin
      mag_s = '0;
    end
    term_s      = digit_s.neg ? -mag_s : mag_s;
    acc_sum_s   = acc_r + (term_s <<< EW);
    acc_shift_s = acc_sum_s >>> 2;
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) state_nxt_s = BUSY;
        else          state_nxt_s = IDLE;
      end
      BUSY: begin
        if (cnt_r == ITER_C) state_nxt_s = DONE;
        else                 state_nxt_s = BUSY;
      end
      DONE: begin
        if (out_ready) state_nxt_s = IDLE;
        else           state_nxt_s = DONE;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= state_nxt_s;
  end

  // Datapath: capture, iterate, and latch the result on the final BUSY cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_r       <= '0;
      b_r       <= '0;
      prev_r    <= 1'b0;
      cnt_r     <= '0;
      acc_r     <= '0;
      product_r <= '0;
      tag_r     <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            a_r    <= a_ext_s;
            b_r    <= b_ext_s;
            prev_r <= 1'b0;
            acc_r  <= '0;
            tag_r  <= in_tag;
            // A zero operand jumps the counter to the end so the cleared accumulator is the result.
            cnt_r  <= zero_skip_s ? ITER_C : '0;
          end
        end
        BUSY: begin
          if (cnt_r != ITER_C) begin
            acc_r  <= acc_shift_s;
            b_r    <= {2'b00, b_r[EW-1:2]};
            prev_r <= b_r[1];
            cnt_r  <= cnt_r + CNT_W'(1);
          end else begin
            product_r <= acc_r[2*WIDTH-1:0];
          end
        end
        DONE: begin
          product_r <= product_r;
        end
        default: begin
          cnt_r <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_multiplier_r4_seq.sv
// Self-checking bench: directed corner cases plus randomized back-to-back traffic against an arithmetic model.
module tb_booth_multiplier_r4_seq;

  localparam int WIDTH = 9;
  localparam int TAG_W = 4;
  localparam int ITER  = 5;
  localparam int N_RND = 1000;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [WIDTH-1:0]   in_a = '0;
  logic [WIDTH-1:0]   in_b = '0;
  logic               in_signed = 1'b0;
  logic [TAG_W-1:0]   in_tag = '0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [2*WIDTH-1:0] out_product;
  logic [TAG_W-1:0]   out_tag;
  logic               busy;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [2*WIDTH-1:0] prod;
    logic [TAG_W-1:0]   tag;
  } exp_t;

  exp_t exp_q[$];

  booth_multiplier_r4_seq #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .in_signed   (in_signed),
    .in_tag      (in_tag),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_product (out_product),
    .out_tag     (out_tag),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Golden product by plain integer arithmetic.
  function automatic logic [2*WIDTH-1:0] ref_mul(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                                 input logic s);
    longint av, bv, p;
    av = s ? longint'($signed(a)) : longint'(a);
    bv = s ? longint'($signed(b)) : longint'(b);
    p  = av * bv;
    return p[2*WIDTH-1:0];
  endfunction

  function automatic logic [WIDTH-1:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 9'h000;
      1: return 9'h100;
      2: return 9'h1FF;
      3: return 9'h0FF;
      default: return WIDTH'($urandom);
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic s,
                        input logic [TAG_W-1:0] t, input int exp_lat, input string name);
    int lat;
    logic [2*WIDTH-1:0] exp_p;
    exp_p = ref_mul(a, b, s);
    lat = 0;
    while (!in_ready && lat < 50) begin
      tick();
      lat++;
    end
    check_eq({name, "_in_ready"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1; in_a = a; in_b = b; in_signed = s; in_tag = t;
    tick();
    in_valid = 1'b0; in_a = WIDTH'($urandom); in_b = WIDTH'($urandom); in_tag = TAG_W'($urandom);
    lat = 0;
    while (!out_valid && lat < 50) begin
      tick();
      lat++;
    end
    check_eq({name, "_latency"}, 64'(lat), 64'(exp_lat));
    check_eq({name, "_product"}, 64'(out_product), 64'(exp_p));
    check_eq({name, "_tag"}, 64'(out_tag), 64'(t));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_eq({name, "_valid_drop"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    int zero_lat;
    int lat;
    int seen;
    int sent;
    int got;
    int cyc;
    logic [2*WIDTH-1:0] bp_exp;
    exp_t e;

`ifdef BOOTH_MUL_ZERO_SKIP_EN
    zero_lat = 1;
`else
    zero_lat = ITER + 1;
`endif

    // Reset state
    tick();
    tick();
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_product", 64'(out_product), 64'd0);
    check_eq("rst_tag", 64'(out_tag), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_in_ready_low", 64'(in_ready), 64'd0);
    rst_n = 1'b1;
    tick();
    check_eq("rst_in_ready_high", 64'(in_ready), 64'd1);

    // Directed corner cases
    run_op(9'h100, 9'h100, 1'b1, 4'd3, ITER + 1, "s_min_min");
    check_eq("s_min_min_const", 64'(out_product), 64'h10000);
    run_op(9'h1FF, 9'h1FF, 1'b0, 4'd5, ITER + 1, "u_max_max");
    check_eq("u_max_max_const", 64'(out_product), 64'h3FC01);
    run_op(9'h100, 9'h0FF, 1'b1, 4'd9, ITER + 1, "s_min_pos");
    check_eq("s_min_pos_const", 64'(out_product), 64'h30100);
    run_op(9'h000, 9'd123, 1'b0, 4'd12, zero_lat, "zero_a");
    run_op(9'h1FD, 9'd77, 1'b1, 4'd1, ITER + 1, "s_neg3_77");

    // Backpressure: hold the result for 10 cycles while a new request is offered
    in_valid = 1'b1; in_a = 9'd100; in_b = 9'h1FD; in_signed = 1'b1; in_tag = 4'd7;
    tick();
    in_a = 9'd55; in_b = 9'd66; in_tag = 4'd2;
    bp_exp = ref_mul(9'd100, 9'h1FD, 1'b1);
    lat = 0;
    while (!out_valid && lat < 50) begin
      tick();
      lat++;
    end
    check_eq("bp_latency", 64'(lat), 64'(ITER + 1));
    for (int i = 0; i < 10; i++) begin
      check_eq("bp_hold_product", 64'(out_product), 64'(bp_exp));
      check_eq("bp_hold_tag", 64'(out_tag), 64'd7);
      check_eq("bp_in_ready", 64'(in_ready), 64'd0);
      check_eq("bp_valid", 64'(out_valid), 64'd1);
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_eq("bp_after_valid", 64'(out_valid), 64'd0);
    check_eq("bp_after_busy", 64'(busy), 64'd0);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid || busy) seen++;
      tick();
    end
    check_eq("bp_single_transfer", 64'(seen), 64'd0);

    // Reset during the second BUSY cycle
    in_valid = 1'b1; in_a = 9'd200; in_b = 9'd3; in_signed = 1'b0; in_tag = 4'd4;
    tick();
    in_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    check_eq("mid_rst_valid", 64'(out_valid), 64'd0);
    check_eq("mid_rst_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    #1;
    check_eq("mid_rst_in_ready", 64'(in_ready), 64'd1);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid) seen++;
    end
    check_eq("mid_rst_no_stale", 64'(seen), 64'd0);

    // Random back-to-back traffic with random backpressure
    sent = 0; got = 0; cyc = 0;
    while (got < N_RND && cyc < 40000) begin
      in_valid  = (sent < N_RND);
      in_a      = pick_operand();
      in_b      = pick_operand();
      in_signed = 1'($urandom_range(0, 1));
      in_tag    = TAG_W'(sent);
      out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (in_valid && in_ready) begin
        e.prod = ref_mul(in_a, in_b, in_signed);
        e.tag  = in_tag;
        exp_q.push_back(e);
        sent++;
      end
      if (out_valid && out_ready) begin
        check_eq("rnd_expected_pending", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check_eq("rnd_product", 64'(out_product), 64'(e.prod));
          check_eq("rnd_tag", 64'(out_tag), 64'(e.tag));
        end
        got++;
      end
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    check_eq("rnd_all_received", 64'(got), 64'(N_RND));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
